// File: rtl/if2_inst_buffer.sv
// IF2 -> ID instruction queue: circular buffer carrying PC, instruction, ADEF
// and branch-prediction metadata over valid/ready, flushed on any redirect.
module if2_inst_buffer #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned AW    = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          flush,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [31:0]   in_pc,
  input  logic [31:0]   in_inst,
  input  logic          in_adef,
  input  logic          in_branch_bp,
  input  logic          in_answ_bht,
  input  logic          in_answ_ghr,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [31:0]   out_pc,
  output logic [31:0]   out_inst,
  output logic          out_adef,
  output logic          out_branch_bp,
  output logic          out_answ_bht,
  output logic          out_answ_ghr,
  output logic [AW:0]   count
);

  localparam int unsigned CW       = AW + 1;
  localparam logic [31:0] NOP_INST = 32'h0340_0000;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
    logic        adef;
    logic        branch_bp;
    logic        answ_bht;
    logic        answ_ghr;
  } entry_t;

  entry_t          mem_q [DEPTH];
  logic [AW-1:0]   wp_q, wp_d;
  logic [AW-1:0]   rp_q, rp_d;
  logic [CW-1:0]   count_q, count_d;
  entry_t          wr_entry;
  entry_t          head;
  logic            push, pop;

  // Ready depends on occupancy only: no push-through when full.
  assign in_ready  = (count_q != CW'(DEPTH));
  assign out_valid = (count_q != '0);
  assign push      = in_valid && in_ready && !flush;
  assign pop       = out_valid && out_ready && !flush;

  // A fetch-address fault becomes a nop with prediction bits cleared; PC kept for BADV/ERA.
  always_comb begin
    wr_entry.pc        = in_pc;
    wr_entry.adef      = in_adef;
    wr_entry.inst      = in_adef ? NOP_INST : in_inst;
    wr_entry.branch_bp = in_adef ? 1'b0 : in_branch_bp;
    wr_entry.answ_bht  = in_adef ? 1'b0 : in_answ_bht;
    wr_entry.answ_ghr  = in_adef ? 1'b0 : in_answ_ghr;
  end

  // Pointer and occupancy next state; flush overrides any push/pop.
  always_comb begin
    wp_d    = wp_q;
    rp_d    = rp_q;
    count_d = count_q;
    if (flush) begin
      wp_d    = '0;
      rp_d    = '0;
      count_d = '0;
    end else begin
      if (push) wp_d = wp_q + AW'(1);
      if (pop)  rp_d = rp_q + AW'(1);
      case ({push, pop})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wp_q    <= '0;
      rp_q    <= '0;
      count_q <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      wp_q    <= wp_d;
      rp_q    <= rp_d;
      count_q <= count_d;
      if (push) mem_q[wp_q] <= wr_entry;
    end
  end

  assign head          = mem_q[rp_q];
  assign out_pc        = head.pc;
  assign out_inst      = head.inst;
  assign out_adef      = head.adef;
  assign out_branch_bp = head.branch_bp;
  assign out_answ_bht  = head.answ_bht;
  assign out_answ_ghr  = head.answ_ghr;
  assign count         = count_q;

endmodule

// File: tb/tb_if2_inst_buffer.sv
// Bench for if2_inst_buffer: directed scenarios plus random traffic against a queue model.
module tb_if2_inst_buffer;

  localparam int unsigned DEPTH = 4;
  localparam int unsigned AW    = 2;
  localparam logic [31:0] NOP   = 32'h0340_0000;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] inst;
    logic        adef;
    logic        bp;
    logic        bht;
    logic        ghr;
  } ent_t;

  logic        clk, rst, flush, in_valid, in_ready, out_valid, out_ready;
  logic [31:0] in_pc, in_inst, out_pc, out_inst;
  logic        in_adef, in_branch_bp, in_answ_bht, in_answ_ghr;
  logic        out_adef, out_branch_bp, out_answ_bht, out_answ_ghr;
  logic [AW:0] count;

  int   tests = 0;
  int   fails = 0;
  ent_t mq[$];

  if2_inst_buffer #(.DEPTH(DEPTH), .AW(AW)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_pc(in_pc), .in_inst(in_inst),
    .in_adef(in_adef), .in_branch_bp(in_branch_bp), .in_answ_bht(in_answ_bht),
    .in_answ_ghr(in_answ_ghr),
    .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc), .out_inst(out_inst),
    .out_adef(out_adef), .out_branch_bp(out_branch_bp), .out_answ_bht(out_answ_bht),
    .out_answ_ghr(out_answ_ghr), .count(count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic set_in(input logic v, input logic [31:0] pc, input logic [31:0] inst,
                        input logic adef, input logic bp, input logic bht, input logic ghr,
                        input logic ordy, input logic fl);
    in_valid = v; in_pc = pc; in_inst = inst; in_adef = adef;
    in_branch_bp = bp; in_answ_bht = bht; in_answ_ghr = ghr;
    out_ready = ordy; flush = fl;
  endtask

  // Advance one clock, updating the model from the inputs that were present at the edge.
  task automatic tick();
    bit   do_push, do_pop, do_rst, do_flush;
    ent_t e;
    do_rst   = rst;
    do_flush = flush;
    do_push  = in_valid && (mq.size() < DEPTH) && !flush;
    do_pop   = (mq.size() > 0) && out_ready && !flush;
    e.pc   = in_pc;
    e.adef = in_adef;
    e.inst = in_adef ? NOP : in_inst;
    e.bp   = in_adef ? 1'b0 : in_branch_bp;
    e.bht  = in_adef ? 1'b0 : in_answ_bht;
    e.ghr  = in_adef ? 1'b0 : in_answ_ghr;
    @(posedge clk);
    if (do_rst || do_flush) mq.delete();
    else begin
      if (do_pop)  void'(mq.pop_front());
      if (do_push) mq.push_back(e);
    end
    #1;
  endtask

  task automatic check_model(input string tag);
    chk({tag, ".out_valid"}, 32'(out_valid), 32'(mq.size() != 0));
    chk({tag, ".in_ready"},  32'(in_ready),  32'(mq.size() != DEPTH));
    chk({tag, ".count"},     32'(count),     32'(mq.size()));
    if (mq.size() != 0) begin
      chk({tag, ".out_pc"},   out_pc,              mq[0].pc);
      chk({tag, ".out_inst"}, out_inst,            mq[0].inst);
      chk({tag, ".out_flags"},
          32'({out_adef, out_branch_bp, out_answ_bht, out_answ_ghr}),
          32'({mq[0].adef, mq[0].bp, mq[0].bht, mq[0].ghr}));
    end
  endtask

  initial begin
    rst = 1'b1;
    set_in(1'b0, '0, '0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    tick(); tick();
    rst = 1'b0;

    // Reset state
    chk("rst.out_valid", 32'(out_valid), 32'd0);
    chk("rst.in_ready",  32'(in_ready),  32'd1);
    chk("rst.count",     32'(count),     32'd0);
    chk("rst.out_pc",    out_pc,         32'd0);
    chk("rst.out_inst",  out_inst,       32'd0);
    chk("rst.flags", 32'({out_adef, out_branch_bp, out_answ_bht, out_answ_ghr}), 32'd0);

    // Single push, one-cycle latency
    set_in(1'b1, 32'h1c00_0000, 32'h0280_0421, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    chk("first.out_pc",   out_pc,   32'h1c00_0000);
    chk("first.out_inst", out_inst, 32'h0280_0421);
    chk("first.count",    32'(count), 32'd1);
    check_model("first");

    // Fill to DEPTH, then a rejected fifth push
    for (int i = 1; i < 4; i++) begin
      set_in(1'b1, 32'h1c00_0000 + 32'(4 * i), 32'h1000_0000 + 32'(i), 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
      tick();
      check_model("fill");
    end
    chk("full.count",    32'(count),    32'd4);
    chk("full.in_ready", 32'(in_ready), 32'd0);
    set_in(1'b1, 32'h1c00_0010, 32'hffff_ffff, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    chk("full.reject", 32'(count), 32'd4);
    check_model("full");

    // Drain in order
    for (int i = 0; i < 4; i++) begin
      chk("drain.order", out_pc, 32'h1c00_0000 + 32'(4 * i));
      set_in(1'b0, '0, '0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
      tick();
      check_model("drain");
    end
    chk("drain.out_valid", 32'(out_valid), 32'd0);

    // Steady stream: count holds at 1, pointers wrap
    for (int i = 0; i < 10; i++) begin
      set_in(1'b1, 32'h1c00_0100 + 32'(4 * i), 32'h2000_0000 + 32'(i), 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
      tick();
      chk("stream.count",  32'(count), 32'd1);
      chk("stream.out_pc", out_pc, 32'h1c00_0100 + 32'(4 * i));
      check_model("stream");
    end
    set_in(1'b0, '0, '0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    tick();

    // Flush with push and pop requested
    for (int i = 0; i < 3; i++) begin
      set_in(1'b1, 32'h1c00_0200 + 32'(4 * i), 32'h3000_0000 + 32'(i), 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      tick();
    end
    chk("preflush.count", 32'(count), 32'd3);
    set_in(1'b1, 32'h1c00_0300, 32'h4000_0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    tick();
    chk("flush.count",     32'(count),     32'd0);
    chk("flush.out_valid", 32'(out_valid), 32'd0);
    tick();
    chk("flush2.count", 32'(count), 32'd0);
    set_in(1'b1, 32'h1c00_0400, 32'h5000_0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    chk("postflush.out_pc", out_pc,      32'h1c00_0400);
    chk("postflush.count",  32'(count),  32'd1);
    check_model("postflush");
    set_in(1'b0, '0, '0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    tick();

    // ADEF entry
    set_in(1'b1, 32'h1c00_0002, 32'hdead_beef, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    tick();
    chk("adef.out_adef", 32'(out_adef),      32'd1);
    chk("adef.out_inst", out_inst,           32'h0340_0000);
    chk("adef.out_bp",   32'(out_branch_bp), 32'd0);
    chk("adef.out_pc",   out_pc,             32'h1c00_0002);
    check_model("adef");

    // Reset mid-operation with a push pending
    set_in(1'b1, 32'h1c00_0500, 32'h6000_0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    chk("prerst.count", 32'(count), 32'd2);
    rst = 1'b1;
    set_in(1'b1, 32'h1c00_0600, 32'h7000_0000, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    tick();
    rst = 1'b0;
    set_in(1'b0, '0, '0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("midrst.count",     32'(count),     32'd0);
    chk("midrst.out_valid", 32'(out_valid), 32'd0);
    chk("midrst.in_ready",  32'(in_ready),  32'd1);
    chk("midrst.out_pc",    out_pc,         32'd0);

    // Random traffic against the queue model
    for (int n = 0; n < 400; n++) begin
      rst = ($urandom_range(0, 99) == 0);
      set_in(1'($urandom_range(0, 2) != 0), $urandom, $urandom,
             1'($urandom_range(0, 7) == 0), 1'($urandom), 1'($urandom), 1'($urandom),
             1'($urandom_range(0, 2) == 0), 1'($urandom_range(0, 19) == 0));
      tick();
      check_model("rand");
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/if2_inst_buffer.md
Name: if2_inst_buffer

Overview:
- Instruction queue between the IF2 stage and the IF2/ID boundary.
- Accepts one fetched instruction per cycle from IF2 and presents it to decode over a valid/ready handshake.
- Carries the instruction's PC, ADEF exception flag and branch-prediction metadata alongside it.
- Decouples fetch from decode stalls; flushed on any redirect (branch mispredict, exception, ertn).

Parameters:
- DEPTH, 4, number of entries; power of two, >= 2.
- AW, 2, pointer width; equals log2(DEPTH).

Ports:
- clk  input  1  clock, all state updates on rising edge
- rst  input  1  synchronous, active-high reset
- flush  input  1  discard all entries and any same-cycle push
- in_valid  input  1  IF2 presents a fetched instruction
- in_ready  output  1  buffer can accept this cycle
- in_pc  input  32  PC of the fetched instruction
- in_inst  input  32  instruction word from icache
- in_adef  input  1  fetch-address exception flag
- in_branch_bp  input  1  predictor predicted taken
- in_answ_bht  input  1  BHT answer bit
- in_answ_ghr  input  1  GHR answer bit
- out_valid  output  1  head entry valid for ID
- out_ready  input  1  ID consumes head this cycle
- out_pc  output  32  head PC
- out_inst  output  32  head instruction
- out_adef  output  1  head ADEF flag
- out_branch_bp  output  1  head predicted-taken bit
- out_answ_bht  output  1  head BHT bit
- out_answ_ghr  output  1  head GHR bit
- count  output  AW+1  occupied entries, 0..DEPTH

Behaviour:
- Interface: clock is clk; reset is rst, synchronous and active-high (fixed).
- Storage is a circular buffer with a write pointer (wp), a read pointer (rp) and count, all registers.
- Pointers wrap modulo DEPTH; count never exceeds DEPTH.
- push = in_valid && in_ready && !flush.
- pop = out_valid && out_ready && !flush.
- in_ready = (count != DEPTH). It is combinational from count only and does not depend on out_ready, so there is no push-through when full.
- out_valid = (count != 0).
- out_* are driven combinationally from entry[rp]. The head entry's fields stay stable while out_valid && !out_ready.
- Latency: an entry pushed at edge N is visible on out_* after edge N; minimum in-to-out latency is 1 cycle. There is no bypass when empty.
- Push and pop in the same cycle: count is unchanged and both pointers advance. This is legal at any count 1..DEPTH-1.
- ADEF entries: when in_adef=1, the stored inst is forced to 32'h03400000 (nop), and branch_bp, answ_bht and answ_ghr are stored as 0. pc is stored unmodified for BADV/ERA.
- Flush (priority below rst, above push/pop):
  - Next edge: wp=rp=0, count=0.
  - Push and pop in the flush cycle are ignored.
  - out_valid=0 from the cycle after flush.
  - During the flush cycle itself, out_* keep their current value, but ID must not consume (pop is masked).
  - Back-to-back flush cycles are legal and keep the buffer empty.
- Reset (rst=1 at edge):
  - wp=rp=0, count=0.
  - All entries cleared to pc=0, inst=0, flags=0.
  - Resulting outputs: out_valid=0, in_ready=1, count=0, out_pc=0, out_inst=0, out_* flags 0.
  - Reset mid-operation discards all entries identically.
- Data held in empty slots is don't-care except after reset.

Test Plan:
- Reset, then push pc=0x1c000000/inst=0x02800421, out_ready=0 -> after one edge: out_valid=1, out_pc=0x1c000000, out_inst=0x02800421, count=1.
- Push 4 entries (pc 0x1c000000..0x1c00000c) with out_ready=0 -> count=4, in_ready=0. A 5th in_valid is not accepted. Then pop 4 -> PCs emerge in order, count returns to 0, out_valid=0.
- Steady stream with in_valid=out_ready=1 for 10 cycles -> count stays at 1 after the first edge. Each cycle out_pc advances by 4; wp/rp wrap past 3 with no loss or duplication.
- 3 entries queued, flush=1 with in_valid=1 and out_ready=1 -> next cycle count=0, out_valid=0, no pop is counted. A push the following cycle appears as the sole head entry.
- Push with in_adef=1, pc=0x1c000002, inst=0xdeadbeef, branch_bp=1 -> out_adef=1, out_inst=0x03400000, out_branch_bp=0, out_pc=0x1c000002.
- With count=2, assert rst for one cycle while in_valid=1 -> count=0, out_valid=0, in_ready=1, out_pc=0. The pushed entry is not retained.
